parity_tester_axis: RTL and testbench

Parametrised AXI-Stream parity checker, successor to the fixed-width parity tester. Consumes packets on an AXI-Stream slave port, checks every beat against a configurable even/odd parity rule (MSB of each beat is the parity bit), and counts beats and parity errors per packet. It emits one status beat per packet on an AXI-Stream master port. It sits at the end of a test datapath as the checking sink and status source for the bench or the host.

---
 rtl/parity_tester_axis.sv | 108 ++++++++++
 tb/tb_parity_tester_axis.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/parity_tester_axis.sv
// parity_tester_axis: AXI-Stream parity checking sink with a per-packet status source.
// Every slave beat is checked against an even/odd rule (MSB is the parity bit),
// beats and parity errors are counted per packet, and one single-beat status
// packet {err_cnt, beat_cnt} is emitted after each tlast beat.
// Optional feature macro: PARITY_TESTER_SAT_EN (defined = saturating counters,
// undefined = counters wrap modulo 2^CNT_W).
module parity_tester_axis #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8,
    parameter int ODD    = 0
) (
    input  logic                 inclock,
    input  logic                 inreset_n,
    input  logic                 axis_s_tvalid,
    input  logic [DATA_W-1:0]    axis_s_tdata,
    input  logic                 axis_s_tlast,
    output logic                 axis_s_tready,
    output logic                 axis_m_tvalid,
    output logic [2*CNT_W-1:0]   axis_m_tdata,
    output logic                 axis_m_tlast,
    input  logic                 axis_m_tready
);

    localparam logic [0:0] S_ACC = 1'b0;
    localparam logic [0:0] S_RES = 1'b1;

    localparam logic             ParityTarget = (ODD != 0);
    localparam logic [CNT_W-1:0] CntMax       = {CNT_W{1'b1}};

    logic [0:0]         state_q, state_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [2*CNT_W-1:0] status_q, status_d;
    logic               rdy_en_q;

    logic               accept;
    logic               beat_err;
    logic [CNT_W-1:0]   beat_cnt_inc;
    logic [CNT_W-1:0]   err_cnt_inc;

    // Counter increment: saturating or wrapping depending on the build option
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] value);
`ifdef PARITY_TESTER_SAT_EN
        cnt_inc = (value == CntMax) ? CntMax : value + CNT_W'(1);
`else
        cnt_inc = value + CNT_W'(1);
`endif
    endfunction

    // Ready depends only on registered state; held low in the cycle reset is active
    assign axis_s_tready = rdy_en_q && (state_q == S_ACC);
    assign axis_m_tvalid = (state_q == S_RES);
    assign axis_m_tlast  = (state_q == S_RES);
    assign axis_m_tdata  = status_q;

    assign accept       = axis_s_tvalid && axis_s_tready;
    assign beat_err     = (^axis_s_tdata) != ParityTarget;
    assign beat_cnt_inc = cnt_inc(beat_cnt_q);
    assign err_cnt_inc  = beat_err ? cnt_inc(err_cnt_q) : err_cnt_q;

    // Next-state logic: count accepted beats, latch status on tlast, clear on handshake
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        err_cnt_d  = err_cnt_q;
        status_d   = status_q;
        case (state_q)
            S_ACC: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_inc;
                    err_cnt_d  = err_cnt_inc;
                    if (axis_s_tlast) begin
                        state_d  = S_RES;
                        status_d = {err_cnt_inc, beat_cnt_inc};
                    end
                end
            end
            S_RES: begin
                if (axis_m_tready) begin
                    state_d    = S_ACC;
                    beat_cnt_d = '0;
                    err_cnt_d  = '0;
                end
            end
            default: begin
                state_d = S_ACC;
            end
        endcase
    end

    // State, counter and status registers with synchronous active-low reset
    always_ff @(posedge inclock) begin
        if (!inreset_n) begin
            state_q    <= S_ACC;
            beat_cnt_q <= '0;
            err_cnt_q  <= '0;
            status_q   <= '0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            err_cnt_q  <= err_cnt_d;
            status_q   <= status_d;
            rdy_en_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_parity_tester_axis.sv
// tb_parity_tester_axis: directed, table-driven bench for parity_tester_axis.
// Two instances: an even-parity one and an odd-parity one sharing the slave inputs.
module tb_parity_tester_axis;

    logic        clk;
    logic        rstN;
    logic        sel;
    logic        sValid;
    logic [7:0]  sData;
    logic        sLast;
    logic        mReady;

    logic        rdyE, vE, lE;
    logic [15:0] dE;
    logic        rdyO, vO, lO;
    logic [15:0] dO;

    logic        sValidE, sValidO;
    logic        sTready, mValid, mLast;
    logic [15:0] mData;

    int checks;
    int fails;
    int hsE;

    typedef struct {
        logic            sel;
        int              nBeats;
        logic [3:0][7:0] data;
        logic [15:0]     expStatus;
    } vector_t;

    vector_t vecs[7];

    assign sValidE = sValid & ~sel;
    assign sValidO = sValid & sel;
    assign sTready = sel ? rdyO : rdyE;
    assign mValid  = sel ? vO : vE;
    assign mLast   = sel ? lO : lE;
    assign mData   = sel ? dO : dE;

    parity_tester_axis #(.DATA_W(8), .CNT_W(8), .ODD(0)) dutEven (
        .inclock       (clk),
        .inreset_n     (rstN),
        .axis_s_tvalid (sValidE),
        .axis_s_tdata  (sData),
        .axis_s_tlast  (sLast),
        .axis_s_tready (rdyE),
        .axis_m_tvalid (vE),
        .axis_m_tdata  (dE),
        .axis_m_tlast  (lE),
        .axis_m_tready (mReady)
    );

    parity_tester_axis #(.DATA_W(8), .CNT_W(8), .ODD(1)) dutOdd (
        .inclock       (clk),
        .inreset_n     (rstN),
        .axis_s_tvalid (sValidO),
        .axis_s_tdata  (sData),
        .axis_s_tlast  (sLast),
        .axis_s_tready (rdyO),
        .axis_m_tvalid (vO),
        .axis_m_tdata  (dO),
        .axis_m_tlast  (lO),
        .axis_m_tready (mReady)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count status handshakes on the even instance
    always @(posedge clk) begin
        if (rstN && vE && mReady) hsE++;
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded wait)
    task automatic applyStimulus(input logic [7:0] data, input logic last);
        int budget;
        sValid = 1'b1;
        sData  = data;
        sLast  = last;
        budget = 20;
        while (!sTready && budget > 0) begin
            tick();
            budget--;
        end
        if (!sTready) begin
            checks++;
            fails++;
            $display("[TB] FAIL beat_accept_timeout: got tready=0, expected tready=1");
        end
        tick();
    endtask

    task automatic endPacket();
        sValid = 1'b0;
        sLast  = 1'b0;
        sData  = 8'h00;
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        hsE    = 0;
        rstN   = 1'b0;
        sel    = 1'b0;
        sValid = 1'b0;
        sData  = 8'h00;
        sLast  = 1'b0;
        mReady = 1'b1;

        vecs[0] = '{1'b0, 3, {8'h00, 8'h03, 8'h81, 8'h00}, 16'h0003};
        vecs[1] = '{1'b0, 2, {8'h00, 8'h00, 8'h80, 8'h01}, 16'h0202};
        vecs[2] = '{1'b1, 1, {8'h00, 8'h00, 8'h00, 8'h01}, 16'h0001};
        vecs[3] = '{1'b1, 1, {8'h00, 8'h00, 8'h00, 8'h00}, 16'h0101};
        vecs[4] = '{1'b0, 1, {8'h00, 8'h00, 8'h00, 8'hFF}, 16'h0001};
        vecs[5] = '{1'b0, 4, {8'h01, 8'hAA, 8'h55, 8'h7F}, 16'h0204};
        vecs[6] = '{1'b1, 4, {8'h80, 8'h07, 8'h03, 8'h00}, 16'h0204};

        // Reset state
        repeat (3) tick();
        checkOutput("reset_even_tvalid", {15'd0, vE}, 16'd0);
        checkOutput("reset_even_tdata", dE, 16'd0);
        checkOutput("reset_even_tlast", {15'd0, lE}, 16'd0);
        checkOutput("reset_even_tready", {15'd0, rdyE}, 16'd0);
        checkOutput("reset_odd_tvalid", {15'd0, vO}, 16'd0);
        checkOutput("reset_odd_tready", {15'd0, rdyO}, 16'd0);
        rstN = 1'b1;
        tick();
        checkOutput("tready_after_reset", {15'd0, rdyE}, 16'd1);

        // Table-driven packets with downstream always ready
        for (int v = 0; v < 7; v++) begin
            sel = vecs[v].sel;
            for (int b = 0; b < vecs[v].nBeats; b++) begin
                applyStimulus(vecs[v].data[b], (b == vecs[v].nBeats - 1));
            end
            endPacket();
            checkOutput($sformatf("vec%0d_tvalid", v), {15'd0, mValid}, 16'd1);
            checkOutput($sformatf("vec%0d_tlast", v), {15'd0, mLast}, 16'd1);
            checkOutput($sformatf("vec%0d_status", v), mData, vecs[v].expStatus);
            checkOutput($sformatf("vec%0d_sready_in_res", v), {15'd0, sTready}, 16'd0);
            tick();
            checkOutput($sformatf("vec%0d_tvalid_after", v), {15'd0, mValid}, 16'd0);
            checkOutput($sformatf("vec%0d_sready_after", v), {15'd0, sTready}, 16'd1);
        end

        // Backpressure: status held for 5 cycles, handshake on the 6th
        sel    = 1'b0;
        mReady = 1'b0;
        applyStimulus(8'h01, 1'b1);
        endPacket();
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp%0d_tvalid", i), {15'd0, mValid}, 16'd1);
            checkOutput($sformatf("bp%0d_status", i), mData, 16'h0101);
            checkOutput($sformatf("bp%0d_sready", i), {15'd0, sTready}, 16'd0);
            tick();
        end
        checkOutput("bp_cycle6_tvalid", {15'd0, mValid}, 16'd1);
        mReady = 1'b1;
        tick();
        checkOutput("bp_tvalid_after", {15'd0, mValid}, 16'd0);
        checkOutput("bp_sready_after", {15'd0, sTready}, 16'd1);

        // Overflow: 300 erroneous beats
        sel = 1'b0;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(8'h01, (i == 299));
        end
        endPacket();
        checkOutput("ovf_tvalid", {15'd0, mValid}, 16'd1);
`ifdef PARITY_TESTER_SAT_EN
        checkOutput("ovf_status", mData, 16'hFFFF);
`else
        checkOutput("ovf_status", mData, 16'h2C2C);
`endif
        tick();

        // Reset mid-packet: partial packet discarded
        sel = 1'b0;
        hsE = 0;
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h01, 1'b0);
        endPacket();
        rstN = 1'b0;
        tick();
        checkOutput("midrst_tvalid", {15'd0, vE}, 16'd0);
        checkOutput("midrst_tready", {15'd0, rdyE}, 16'd0);
        rstN = 1'b1;
        applyStimulus(8'h00, 1'b1);
        endPacket();
        checkOutput("midrst_status", mData, 16'h0001);
        tick();
        repeat (3) tick();
        checkOutput("midrst_status_count", 16'(hsE), 16'd1);

        // Reset while status pending
        mReady = 1'b0;
        applyStimulus(8'h80, 1'b1);
        endPacket();
        checkOutput("resrst_tvalid_before", {15'd0, vE}, 16'd1);
        rstN = 1'b0;
        tick();
        checkOutput("resrst_tvalid", {15'd0, vE}, 16'd0);
        checkOutput("resrst_tdata", dE, 16'd0);
        rstN   = 1'b1;
        mReady = 1'b1;
        tick();
        checkOutput("resrst_tready_after", {15'd0, rdyE}, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
